// File: rtl/crc32_pkg.sv
// Shared constants for the 16-bit-per-cycle CRC-32 generator.
// Polynomial 0x04C11DB7, MSB-first, seed all ones.
package crc32_pkg;

  localparam int CRC32_W = 32;
  localparam int DATA_W  = 16;

  localparam logic [CRC32_W-1:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [CRC32_W-1:0] CRC32_SEED = 32'hFFFFFFFF;

endpackage

// File: rtl/crc32_d16_step.sv
// Combinational CRC-32 advance over one 16-bit word.
// Consumes data bit 15 first and unrolls all 16 serial shift steps.
module crc32_d16_step
  import crc32_pkg::*;
(
  input  logic [CRC32_W-1:0] crc_in,
  input  logic [DATA_W-1:0]  data,
  output logic [CRC32_W-1:0] crc_next
);

  logic [CRC32_W-1:0] crc_acc;
  logic               fb;

  always_comb begin
    crc_acc = crc_in;
    fb      = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb      = crc_acc[CRC32_W-1] ^ data[i];
      crc_acc = {crc_acc[CRC32_W-2:0], 1'b0} ^ (fb ? CRC32_POLY : '0);
    end
    crc_next = crc_acc;
  end

endmodule

// File: rtl/crc32_d16.sv
// Running CRC-32 accumulator: one 16-bit word per enabled cycle, reseeded on each enable rising edge.
// Optional build macro CRC32_D16_FINAL_XOR_EN presents the complemented register on crc_out.
module crc32_d16
  import crc32_pkg::*;
(
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               enable_crc,
  output logic [CRC32_W-1:0] crc_out
);

  logic [CRC32_W-1:0] crc_reg;
  logic [CRC32_W-1:0] crc_start;
  logic [CRC32_W-1:0] crc_next;
  logic               en_d;

  // The first enabled cycle after a gap starts from the seed, so frames need no explicit clear.
  assign crc_start = en_d ? crc_reg : CRC32_SEED;

  crc32_d16_step u_step (
    .crc_in   (crc_start),
    .data     (data_in),
    .crc_next (crc_next)
  );

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      crc_reg <= CRC32_SEED;
      en_d    <= 1'b0;
    end else begin
      en_d <= enable_crc;
      if (enable_crc) begin
        crc_reg <= crc_next;
      end
    end
  end

`ifdef CRC32_D16_FINAL_XOR_EN
  assign crc_out = ~crc_reg;
`else
  assign crc_out = crc_reg;
`endif

endmodule

// File: tb/tb_crc32_d16.sv
// Self-checking bench for crc32_d16: random frames against a whole-frame bit-serial reference.
// Expected outputs follow CRC32_D16_FINAL_XOR_EN when the bench is built with it.
module tb_crc32_d16;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic        enable_crc;
  logic [31:0] crc_out;

  int numChecks = 0;
  int numFails  = 0;

  bit          frameBits[$];
  logic [31:0] modelCrc;
  bit          prevEn;

  crc32_d16 dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .enable_crc (enable_crc),
    .crc_out    (crc_out)
  );

  always #5 sys_clk = ~sys_clk;

  // CRC of an entire frame's bitstream computed from scratch, one bit at a time.
  function automatic logic [31:0] refCrc(input bit bits[$]);
    logic [31:0] c = SEED;
    foreach (bits[k]) begin
      if (c[31] ^ bits[k]) c = {c[30:0], 1'b0} ^ POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [31:0] outOf(input logic [31:0] raw);
`ifdef CRC32_D16_FINAL_XOR_EN
    return ~raw;
`else
    return raw;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, actual, expected);
    end
  endtask

  // Drives one cycle, advances the frame model and checks crc_out just after the edge.
  task automatic applyStimulus(input string tag, input bit rst, input bit en, input logic [15:0] d);
    rst_n      = rst;
    enable_crc = en;
    data_in    = d;
    @(posedge sys_clk);
    #1;
    if (!rst) begin
      frameBits.delete();
      modelCrc = SEED;
      prevEn   = 1'b0;
    end else if (en) begin
      if (!prevEn) frameBits.delete();
      for (int i = 15; i >= 0; i--) frameBits.push_back(d[i]);
      modelCrc = refCrc(frameBits);
      prevEn   = 1'b1;
    end else begin
      prevEn = 1'b0;
    end
    checkOutput(tag, crc_out, outOf(modelCrc));
  endtask

  initial begin
    logic [31:0] capC;
    logic [31:0] refB;
    logic [15:0] frameB[4];
    bit          bBits[$];
    int          len;
    int          gap;

    rst_n      = 1'b0;
    enable_crc = 1'b1;
    data_in    = 16'h1234;
    modelCrc   = SEED;
    prevEn     = 1'b0;

    // Reset dominates enable, then release with enable low.
    applyStimulus("reset0", 1'b0, 1'b1, 16'hA5A5);
    applyStimulus("reset1", 1'b0, 1'b1, 16'h5A5A);
    checkOutput("reset_const", crc_out, outOf(32'hFFFFFFFF));
    applyStimulus("release", 1'b1, 1'b0, 16'h0000);

    // Single all-ones word.
    applyStimulus("single", 1'b1, 1'b1, 16'hFFFF);
    checkOutput("single_const", crc_out, outOf(32'hFFFF0000));
    applyStimulus("single_hold", 1'b1, 1'b0, 16'h1111);
    applyStimulus("single_hold2", 1'b1, 1'b0, 16'h2222);

    // Random frames with random gaps.
    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(1, 64);
      for (int w = 0; w < len; w++)
        applyStimulus("rand_frame", 1'b1, 1'b1, 16'($urandom));
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++)
        applyStimulus("rand_gap", 1'b1, 1'b0, 16'($urandom));
    end

    // Appending the raw CRC to its own frame leaves a zero remainder.
    len = $urandom_range(1, 16);
    for (int w = 0; w < len; w++)
      applyStimulus("residue_frame", 1'b1, 1'b1, 16'($urandom));
    capC = modelCrc;
    applyStimulus("residue_hi", 1'b1, 1'b1, capC[31:16]);
    applyStimulus("residue_lo", 1'b1, 1'b1, capC[15:0]);
    checkOutput("residue_zero", crc_out, outOf(32'h00000000));
    applyStimulus("residue_gap", 1'b1, 1'b0, 16'h0000);

    // Frame B after frame A and a one-cycle gap equals B on its own.
    for (int w = 0; w < 4; w++) begin
      frameB[w] = 16'($urandom);
      for (int i = 15; i >= 0; i--) bBits.push_back(frameB[w][i]);
    end
    refB = refCrc(bBits);
    for (int w = 0; w < 5; w++)
      applyStimulus("frame_a", 1'b1, 1'b1, 16'($urandom));
    applyStimulus("a_gap", 1'b1, 1'b0, 16'hFFFF);
    for (int w = 0; w < 4; w++)
      applyStimulus("frame_b", 1'b1, 1'b1, frameB[w]);
    checkOutput("restart_b", crc_out, outOf(refB));

    // Same B result when A is cut short by reset.
    applyStimulus("b_gap", 1'b1, 1'b0, 16'h0000);
    for (int w = 0; w < 3; w++)
      applyStimulus("frame_a2", 1'b1, 1'b1, 16'($urandom));
    applyStimulus("mid_reset", 1'b0, 1'b1, 16'hBEEF);
    for (int w = 0; w < 4; w++)
      applyStimulus("frame_b2", 1'b1, 1'b1, frameB[w]);
    checkOutput("reset_restart_b", crc_out, outOf(refB));
    applyStimulus("final_hold", 1'b1, 1'b0, 16'h0000);
    checkOutput("final_hold_b", crc_out, outOf(refB));

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/crc32_d16.md
# crc32_d16

16-bit-per-cycle CRC-32 generator for the frame transmit path. It accumulates a running CRC-32 (polynomial 0x04C11DB7, MSB-first) over one 16-bit data word per enabled clock. It presents the raw CRC register to the frame-assembly logic, which appends it to the outgoing frame (upper half first, optionally inverted). The block is purely a datapath accumulator: it has no framing, handshake, or CRC insertion of its own.

## Interface
- No parameters; polynomial and seed are fixed package constants.
- sys_clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low; sampled on the sys_clk rising edge.
- data_in  input  16  data word; bit 15 enters the CRC first.
- enable_crc  input  1  high: fold data_in into the CRC this cycle; low: hold the CRC.
- crc_out  output  32  current CRC register, bit 31 = MSB (x^31 coefficient).

## Operation
- Registers:
  - crc_reg[31:0]
  - en_d, the enable_crc value from the previous cycle.
- Seed: 0xFFFFFFFF.
- Update per enabled cycle: 16 serial steps, i = 15 down to 0:
  - fb = crc[31] ^ data_in[i]
  - crc = {crc[30:0], 1'b0} ^ (fb ? 0x04C11DB7 : 0)
- Start of frame: when enable_crc = 1 and en_d = 0, the 16-step update starts from the seed, not from crc_reg. A new frame therefore needs no explicit clear.
- Continuation: when enable_crc = 1 and en_d = 1, the update starts from crc_reg.
- Hold: when enable_crc = 0, crc_reg keeps its value, so the finished CRC remains readable after the frame ends.
- Output:
  - No input or output reflection.
  - crc_out = crc_reg, with no final XOR, unless the Configuration macro is defined.
- Reset (rst_n = 0 at a clock edge):
  - crc_reg = 0xFFFFFFFF, en_d = 0.
  - crc_out = 0xFFFFFFFF.
  - Reset has priority over enable_crc.
- Reset mid-frame: the partial CRC is discarded. The next enabled cycle is treated as a start of frame.
- data_in values other than 16 bits wide are not supported.

## Timing
- Latency 1: a word presented with enable_crc = 1 at edge N appears in crc_out after edge N.
- Throughput: one word per cycle, back-to-back, with no stall.
- An enable_crc low gap of one or more cycles ends the frame. The next high cycle reseeds the CRC.
- crc_out is registered, so there is no combinational path from the inputs.

## Configuration
- CRC32_D16_FINAL_XOR_EN:
  - Defined: crc_out = ~crc_reg, the Ethernet final complement, applied combinationally on the register output.
  - Undefined (default): crc_out = crc_reg. The frame assembler applies any inversion itself.

## Structure
- Package crc32_pkg:
  - localparam CRC32_POLY = 32'h04C11DB7
  - localparam CRC32_SEED = 32'hFFFFFFFF
  - CRC32_W = 32, DATA_W = 16
- Sub-module crc32_d16_step: purely combinational.
  - Inputs: crc_in[31:0], data[15:0].
  - Output: crc_next[31:0], the 16 serial steps unrolled.
  - The top instantiates it once and owns the seed mux, crc_reg, en_d and reset.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with enable_crc = 1 -> crc_out = 0xFFFFFFFF. Release with enable_crc = 0 -> crc_out stays 0xFFFFFFFF.
- Single word: enable_crc = 1 for one cycle, data_in = 0xFFFF -> crc_out = 0xFFFF0000 after the edge, then holds while enable_crc = 0.
- Random frames of 1-64 words -> crc_out matches a bit-serial reference model with poly 0x04C11DB7, seed 0xFFFFFFFF, MSB-first, no reflection, no XOR-out, every cycle.
- Zero residue:
  - Run a frame and capture C = crc_out.
  - Continue enabled with data_in = C[31:16], then C[15:0] -> crc_out = 0x00000000.
- Frame restart:
  - Run frame A, drop enable_crc for 1 cycle, then run frame B.
  - crc_out equals the reference CRC of B alone.
  - Frame B gives the same result when rst_n = 0 is pulsed in the middle of frame A.
- Macro build with CRC32_D16_FINAL_XOR_EN: repeat the random-frame test -> crc_out equals the bitwise complement of the reference value; after reset crc_out = 0x00000000.
